// File: rtl/clock_time_reg.sv
// clock_time_reg: BCD time-of-day register with run/set-hours/set-minutes modes.
// Define CLOCK_12HR_EN for 12-hour operation with o_pm; default build is 24-hour.
module clock_time_reg (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_1hz_stb,
    input  logic       i_slow_set_stb,
    input  logic       i_fast_set_stb,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    input  logic       i_fast_set,
    output logic [1:0] o_hours_tens,
    output logic [3:0] o_hours_ones,
    output logic [2:0] o_minutes_tens,
    output logic [3:0] o_minutes_ones,
    output logic [2:0] o_seconds_tens,
    output logic [3:0] o_seconds_ones,
    output logic       o_pm,
    output logic       o_time_stb
);
    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;

`ifdef CLOCK_12HR_EN
    localparam logic [1:0] HR_T_RST = 2'd1;
    localparam logic [3:0] HR_O_RST = 4'd2;
`else
    localparam logic [1:0] HR_T_RST = 2'd0;
    localparam logic [3:0] HR_O_RST = 4'd0;
`endif

    state_t     state_q, state_d;
    logic [1:0] hr_t_q, hr_t_d;
    logic [3:0] hr_o_q, hr_o_d;
    logic [2:0] mn_t_q, mn_t_d;
    logic [3:0] mn_o_q, mn_o_d;
    logic [2:0] sc_t_q, sc_t_d;
    logic [3:0] sc_o_q, sc_o_d;
    logic       pm_q, pm_d;
    logic       time_stb_q, time_stb_d;

    logic [1:0] hr_inc_t;
    logic [3:0] hr_inc_o;
    logic       hr_top, hr_toggle;
    logic [2:0] mn_inc_t, sc_inc_t;
    logic [3:0] mn_inc_o, sc_inc_o;
    logic       mn_carry, sc_carry;
    logic       set_stb, min_entry;

`ifdef CLOCK_12HR_EN
    assign hr_top    = hr_t_q == 2'd1 && hr_o_q == 4'd2;
    assign hr_toggle = hr_t_q == 2'd1 && hr_o_q == 4'd1;
    assign hr_inc_t  = hr_top ? 2'd0 : hr_o_q == 4'd9 ? hr_t_q + 2'd1 : hr_t_q;
    assign hr_inc_o  = hr_top ? 4'd1 : hr_o_q == 4'd9 ? 4'd0 : hr_o_q + 4'd1;
`else
    assign hr_top    = hr_t_q == 2'd2 && hr_o_q == 4'd3;
    assign hr_toggle = 1'b0;
    assign hr_inc_t  = hr_top ? 2'd0 : hr_o_q == 4'd9 ? hr_t_q + 2'd1 : hr_t_q;
    assign hr_inc_o  = hr_top ? 4'd0 : hr_o_q == 4'd9 ? 4'd0 : hr_o_q + 4'd1;
`endif

    assign mn_carry = mn_t_q == 3'd5 && mn_o_q == 4'd9;
    assign mn_inc_o = mn_o_q == 4'd9 ? 4'd0 : mn_o_q + 4'd1;
    assign mn_inc_t = mn_o_q != 4'd9 ? mn_t_q : mn_carry ? 3'd0 : mn_t_q + 3'd1;
    assign sc_carry = sc_t_q == 3'd5 && sc_o_q == 4'd9;
    assign sc_inc_o = sc_o_q == 4'd9 ? 4'd0 : sc_o_q + 4'd1;
    assign sc_inc_t = sc_o_q != 4'd9 ? sc_t_q : sc_carry ? 3'd0 : sc_t_q + 3'd1;

    always_comb begin
        state_d   = i_set_hours ? SET_HR : i_set_minutes ? SET_MIN : RUN;
        set_stb   = i_fast_set ? i_fast_set_stb : i_slow_set_stb;
        min_entry = state_d == SET_MIN && state_q != SET_MIN;
        hr_t_d    = hr_t_q;
        hr_o_d    = hr_o_q;
        mn_t_d    = mn_t_q;
        mn_o_d    = mn_o_q;
        sc_t_d    = sc_t_q;
        sc_o_d    = sc_o_q;
        pm_d      = pm_q;
        // Strobes act under the state registered at the start of the cycle.
        if (state_q == RUN && i_1hz_stb) begin
            sc_t_d = sc_inc_t;
            sc_o_d = sc_inc_o;
            if (sc_carry) begin
                mn_t_d = mn_inc_t;
                mn_o_d = mn_inc_o;
            end
            if (sc_carry && mn_carry) begin
                hr_t_d = hr_inc_t;
                hr_o_d = hr_inc_o;
                pm_d   = pm_q ^ hr_toggle;
            end
        end
        if (state_q == SET_HR && set_stb && !min_entry) begin
            hr_t_d = hr_inc_t;
            hr_o_d = hr_inc_o;
            pm_d   = pm_q ^ hr_toggle;
        end
        if (state_q == SET_MIN && set_stb) begin
            mn_t_d = mn_inc_t;
            mn_o_d = mn_inc_o;
        end
        if (min_entry) begin
            sc_t_d = 3'd0;
            sc_o_d = 4'd0;
        end
        time_stb_d = {hr_t_d, hr_o_d, mn_t_d, mn_o_d, sc_t_d, sc_o_d}
                  != {hr_t_q, hr_o_q, mn_t_q, mn_o_q, sc_t_q, sc_o_q};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= RUN;
            hr_t_q     <= HR_T_RST;
            hr_o_q     <= HR_O_RST;
            mn_t_q     <= 3'd0;
            mn_o_q     <= 4'd0;
            sc_t_q     <= 3'd0;
            sc_o_q     <= 4'd0;
            pm_q       <= 1'b0;
            time_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hr_t_q     <= hr_t_d;
            hr_o_q     <= hr_o_d;
            mn_t_q     <= mn_t_d;
            mn_o_q     <= mn_o_d;
            sc_t_q     <= sc_t_d;
            sc_o_q     <= sc_o_d;
            pm_q       <= pm_d;
            time_stb_q <= time_stb_d;
        end
    end

    assign o_hours_tens   = hr_t_q;
    assign o_hours_ones   = hr_o_q;
    assign o_minutes_tens = mn_t_q;
    assign o_minutes_ones = mn_o_q;
    assign o_seconds_tens = sc_t_q;
    assign o_seconds_ones = sc_o_q;
    assign o_pm           = pm_q;
    assign o_time_stb     = time_stb_q;
endmodule

// File: tb/tb_clock_time_reg.sv
// tb_clock_time_reg: directed vectors for clock_time_reg; time is compared as packed BCD hhmmss.
module tb_clock_time_reg;
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_1hz_stb = 1'b0;
    logic       i_slow_set_stb = 1'b0;
    logic       i_fast_set_stb = 1'b0;
    logic       i_set_hours = 1'b0;
    logic       i_set_minutes = 1'b0;
    logic       i_fast_set = 1'b0;
    logic [1:0] o_hours_tens;
    logic [3:0] o_hours_ones;
    logic [2:0] o_minutes_tens;
    logic [3:0] o_minutes_ones;
    logic [2:0] o_seconds_tens;
    logic [3:0] o_seconds_ones;
    logic       o_pm;
    logic       o_time_stb;
    logic [23:0] now;
    int n_vec = 0;
    int n_bad = 0;

    clock_time_reg dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_1hz_stb(i_1hz_stb),
        .i_slow_set_stb(i_slow_set_stb), .i_fast_set_stb(i_fast_set_stb),
        .i_set_hours(i_set_hours), .i_set_minutes(i_set_minutes), .i_fast_set(i_fast_set),
        .o_hours_tens(o_hours_tens), .o_hours_ones(o_hours_ones),
        .o_minutes_tens(o_minutes_tens), .o_minutes_ones(o_minutes_ones),
        .o_seconds_tens(o_seconds_tens), .o_seconds_ones(o_seconds_ones),
        .o_pm(o_pm), .o_time_stb(o_time_stb)
    );

    always #5 i_clk = ~i_clk;

    assign now = {2'b0, o_hours_tens, o_hours_ones, 1'b0, o_minutes_tens, o_minutes_ones,
                  1'b0, o_seconds_tens, o_seconds_ones};

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive strobes for n cycles; returns at a falling edge with strobes low.
    task cyc(input int n, input logic hz, input logic slow, input logic fast);
        for (int k = 0; k < n; k++) begin
            i_1hz_stb = hz;
            i_slow_set_stb = slow;
            i_fast_set_stb = fast;
            @(negedge i_clk);
        end
        i_1hz_stb = 1'b0;
        i_slow_set_stb = 1'b0;
        i_fast_set_stb = 1'b0;
    endtask

    task do_reset;
        i_reset = 1'b1;
        cyc(2, 1'b0, 1'b0, 1'b0);
        i_reset = 1'b0;
    endtask

    task set_time(input int h, input int m, input int s);
        i_fast_set = 1'b0;
        i_set_hours = 1'b1;
        cyc(1, 1'b0, 1'b0, 1'b0);
        cyc(h, 1'b0, 1'b1, 1'b0);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        cyc(1, 1'b0, 1'b0, 1'b0);
        cyc(m, 1'b0, 1'b1, 1'b0);
        i_set_minutes = 1'b0;
        cyc(1, 1'b0, 1'b0, 1'b0);
        cyc(s, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge i_clk);
        do_reset;
`ifdef CLOCK_12HR_EN
        check("rst_time", now, 24'h120000);
        check("rst_pm", o_pm, 0);
        check("rst_stb", o_time_stb, 0);
        set_time(11, 0, 0);
        check("set_hr_11", now, 24'h110000);
        check("set_hr_pm", o_pm, 0);
        set_time(0, 59, 59);
        check("pre_noon", now, 24'h115959);
        cyc(1, 1'b1, 1'b0, 1'b0);
        check("noon", now, 24'h120000);
        check("noon_pm", o_pm, 1);
        check("noon_stb", o_time_stb, 1);
        cyc(3600, 1'b1, 1'b0, 1'b0);
        check("one_pm", now, 24'h010000);
        check("one_pm_pm", o_pm, 1);
`else
        check("rst_time", now, 24'h000000);
        check("rst_pm", o_pm, 0);
        check("rst_stb", o_time_stb, 0);
        i_set_hours = 1'b1;
        cyc(1, 1'b0, 1'b0, 1'b0);
        cyc(23, 1'b0, 1'b1, 1'b0);
        check("set_hr_23", now, 24'h230000);
        cyc(1, 1'b1, 1'b0, 1'b1);
        check("unsel_fast_ign", now, 24'h230000);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b1;
        cyc(1, 1'b0, 1'b0, 1'b0);
        cyc(59, 1'b0, 1'b1, 1'b0);
        check("set_min_59", now, 24'h235900);
        i_set_minutes = 1'b0;
        cyc(1, 1'b0, 1'b0, 1'b0);
        cyc(59, 1'b1, 1'b0, 1'b0);
        check("run_59s", now, 24'h235959);
        cyc(1, 1'b0, 1'b1, 1'b1);
        check("run_set_ign", now, 24'h235959);
        check("run_set_ign_stb", o_time_stb, 0);
        cyc(1, 1'b1, 1'b0, 1'b0);
        check("midnight", now, 24'h000000);
        check("midnight_stb", o_time_stb, 1);
        check("midnight_pm", o_pm, 0);
        cyc(1, 1'b0, 1'b0, 1'b0);
        check("stb_one_cycle", o_time_stb, 0);

        set_time(10, 45, 37);
        check("at_104537", now, 24'h104537);
        i_set_minutes = 1'b1;
        cyc(1, 1'b0, 1'b0, 1'b0);
        check("min_entry_clr", now, 24'h104500);
        check("min_entry_stb", o_time_stb, 1);
        cyc(14, 1'b1, 1'b1, 1'b0);
        check("min_14", now, 24'h105900);
        cyc(1, 1'b1, 1'b1, 1'b0);
        check("min_wrap", now, 24'h100000);
        i_set_minutes = 1'b0;
        cyc(1, 1'b0, 1'b0, 1'b0);

        set_time(12, 10, 5);
        check("at_221005", now, 24'h221005);
        i_set_hours = 1'b1;
        i_set_minutes = 1'b1;
        i_fast_set = 1'b1;
        cyc(1, 1'b0, 1'b0, 1'b0);
        cyc(1, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b1, 1'b0);
        check("fast_1", now, 24'h231005);
        cyc(1, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b1, 1'b0);
        cyc(1, 1'b0, 1'b0, 1'b1);
        cyc(1, 1'b0, 1'b1, 1'b0);
        check("fast_hr_wrap", now, 24'h011005);
        i_set_hours = 1'b0;
        i_set_minutes = 1'b0;
        i_fast_set = 1'b0;
        cyc(1, 1'b0, 1'b0, 1'b0);

        do_reset;
        cyc(9, 1'b1, 1'b0, 1'b0);
        check("at_000009", now, 24'h000009);
        i_reset = 1'b1;
        cyc(1, 1'b1, 1'b0, 1'b0);
        i_reset = 1'b0;
        check("rst_over_hz", now, 24'h000000);
        check("rst_over_hz_stb", o_time_stb, 0);
        cyc(9, 1'b1, 1'b0, 1'b0);
        i_set_minutes = 1'b1;
        cyc(1, 1'b0, 1'b1, 1'b0);
        check("entry_stb_ign", now, 24'h000000);
        i_set_minutes = 1'b0;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_time_reg.md
CLOCK_TIME_REG -- requirements
Module: clock_time_reg

Interface
REQ-001 i_clk  in  1  system clock; all state updates on its rising edge.
REQ-002 i_reset  in  1  reset, synchronous, active-high.
REQ-003 i_1hz_stb  in  1  one-i_clk-wide timekeeping strobe, 1 Hz.
REQ-004 i_slow_set_stb  in  1  one-i_clk-wide set-rate strobe, 2 Hz.
REQ-005 i_fast_set_stb  in  1  one-i_clk-wide set-rate strobe, 8 Hz.
REQ-006 i_set_hours  in  1  level; high = hours-set mode requested.
REQ-007 i_set_minutes  in  1  level; high = minutes-set mode requested.
REQ-008 i_fast_set  in  1  level; high = use i_fast_set_stb, low = use i_slow_set_stb.
REQ-009 o_hours_tens  out  2  BCD hours tens digit.
REQ-010 o_hours_ones  out  4  BCD hours ones digit.
REQ-011 o_minutes_tens  out  3  BCD minutes tens digit.
REQ-012 o_minutes_ones  out  4  BCD minutes ones digit.
REQ-013 o_seconds_tens  out  3  BCD seconds tens digit.
REQ-014 o_seconds_ones  out  4  BCD seconds ones digit.
REQ-015 o_pm  out  1  PM indicator (12-hour build only; otherwise constant 0).
REQ-016 o_time_stb  out  1  one-cycle pulse in the cycle any digit output has just changed.

Function
REQ-017 The FSM SHALL have three states: RUN, SET_HR, SET_MIN.
REQ-018 State transitions SHALL be evaluated every cycle, as follows:
- i_set_hours=1 -> SET_HR (hours takes priority when both set inputs are high).
- else i_set_minutes=1 -> SET_MIN.
- else -> RUN.
REQ-019 Entering SET_MIN from any other state SHALL clear seconds to 00 in the entry cycle; entering SET_HR SHALL NOT modify the time.
REQ-020 In RUN, each i_1hz_stb SHALL advance the time by one second with full BCD carry:
- seconds 59->00 with carry to minutes.
- minutes 59->00 with carry to hours.
- hours 23->00.
REQ-021 In SET_HR and SET_MIN, i_1hz_stb SHALL be ignored; the selected set strobe (REQ-008) SHALL increment only the addressed field.
- Field wraps: hours 23->00, minutes 59->00.
- No carry into any other field.
REQ-022 Strobe handling SHALL be decided by the state registered at the start of the cycle; a strobe coinciding with a state change SHALL act under the old state.
- Exception: a set strobe coinciding with SET_MIN entry SHALL be ignored; REQ-019 still applies.
REQ-023 In RUN, set strobes SHALL be ignored. In set states, the non-selected set strobe SHALL be ignored.
REQ-024 Latency: digit outputs SHALL be registered and SHALL show the new value exactly one cycle after the causing strobe; o_time_stb SHALL be high in that same cycle.
REQ-025 BCD digits SHALL never hold values above 9, nor any value outside their field range.

Reset
REQ-026 i_reset SHALL take priority over all other inputs and SHALL be honoured in any state, including mid-carry.
REQ-027 Reset SHALL set state RUN, time 00:00:00, o_pm=0 and o_time_stb=0 on the next rising edge.
REQ-028 Strobes arriving while i_reset is high SHALL be discarded.

Configuration
REQ-029 With CLOCK_12HR_EN defined, the block SHALL run in 12-hour mode:
- Hours range 01..12; reset value 12:00:00, o_pm=0.
- RUN: 11:59:59->12:00:00 toggles o_pm; hours 12->01 without toggling o_pm.
- SET_HR: 12->01 at the wrap; 11->12 toggles o_pm.
REQ-030 Without CLOCK_12HR_EN, the block SHALL run in 24-hour mode per REQ-020/021, with o_pm tied to 0.

Verification
REQ-031 Reset, then one i_1hz_stb at 23:59:59 (24h) -> 00:00:00 one cycle later, o_time_stb=1 for exactly 1 cycle.
REQ-032 i_set_minutes=1 at 10:45:37, then 15 i_slow_set_stb -> 10:00:00, hours unchanged, i_1hz_stb ignored throughout.
REQ-033 i_set_hours=1 and i_set_minutes=1 with i_fast_set=1, then 3 i_fast_set_stb plus interleaved i_slow_set_stb from 22:10:05 -> 01:10:05.
REQ-034 i_reset asserted in the same cycle as i_1hz_stb at 00:00:09 -> 00:00:00, o_time_stb=0.
REQ-035 CLOCK_12HR_EN build, i_1hz_stb at 11:59:59, o_pm=0 -> 12:00:00, o_pm=1; a further 3600 strobes -> 01:00:00, o_pm=1.
